// File: rtl/d_ff_pkg.sv
// Shared CPU constants for storage cells.
// Holds the default reset value and the datapath width.
`timescale 1ns/1ps
package d_ff_pkg;

   localparam int   DATA_WIDTH = 32;
   localparam logic RESET_ZERO = 1'b0;

endpackage

// File: rtl/d_ff_bit.sv
// One-bit storage cell.
// Load enable is synchronous and reset is asynchronous, active-high.
`timescale 1ns/1ps
module d_ff_bit
   import d_ff_pkg::*;
#(
   parameter logic RESET_VALUE = RESET_ZERO
) (
   output logic q,
   input  logic d,
   input  logic clk,
   input  logic reset,
   input  logic enable
);

   // The ternary lets an unknown enable propagate X into q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_VALUE;
      else
         q <= enable ? d : q;
   end

endmodule

// File: rtl/d_ff.sv
// WIDTH-bit register built from d_ff_bit cells.
// Bit i of RESET_VALUE is the reset value of cell i.
`timescale 1ns/1ps
module d_ff
   import d_ff_pkg::*;
#(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{RESET_ZERO}}
) (
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             clk,
   input  logic             reset,
   input  logic             enable
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff_bit #(
         .RESET_VALUE(RESET_VALUE[i])
      ) u_bit (
         .q     (q[i]),
         .d     (d[i]),
         .clk   (clk),
         .reset (reset),
         .enable(enable)
      );
   end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff.
// Three widths share one clock, reset, enable and data stream.
`timescale 1ns/1ps
module tb_d_ff;
   import d_ff_pkg::*;

   localparam logic [7:0] RV8 = 8'hA5;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        d1 = 1'b0;
   logic [7:0]  d8 = '0;
   logic [31:0] d32 = '0;
   logic        q1;
   logic [7:0]  q8;
   logic [31:0] q32;

   logic        exp1;
   logic [7:0]  exp8;
   logic [31:0] exp32;
   bit          mvalid = 1'b0;

   int checks = 0;
   int failures = 0;

   always #10 clk = ~clk;

   d_ff u_q1 (
      .q(q1), .d(d1), .clk(clk), .reset(reset), .enable(enable)
   );

   d_ff #(
      .WIDTH(8), .RESET_VALUE(RV8)
   ) u_q8 (
      .q(q8), .d(d8), .clk(clk), .reset(reset), .enable(enable)
   );

   d_ff #(
      .WIDTH(DATA_WIDTH), .RESET_VALUE(32'h0000_0000)
   ) u_q32 (
      .q(q32), .d(d32), .clk(clk), .reset(reset), .enable(enable)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h",
                  name, $time, act, req);
      end
   endtask

   task automatic model_reset();
      exp1  = 1'b0;
      exp8  = RV8;
      exp32 = 32'h0;
   endtask

   // Drive inputs mid-cycle, then apply the storage rule at the edge.
   task automatic step(input logic r, input logic e,
                       input logic [31:0] v);
      @(negedge clk);
      reset  = r;
      enable = e;
      d1     = v[0];
      d8     = v[7:0];
      d32    = v;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (e) begin
         exp1  = v[0];
         exp8  = v[7:0];
         exp32 = v;
      end
      #1;
   endtask

   always @(posedge clk) begin
      #2;
      if (mvalid) begin
         chk("cyc_q1", {31'b0, q1}, {31'b0, exp1});
         chk("cyc_q8", {24'b0, q8}, {24'b0, exp8});
         chk("cyc_q32", q32, exp32);
      end
   end

   logic seq [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      #3;
      reset = 1'b1;
      #1;
      chk("por_q1", {31'b0, q1}, 32'h0);
      chk("por_q8", {24'b0, q8}, 32'hA5);
      chk("por_q32", q32, 32'h0);
      model_reset();
      mvalid = 1'b1;
      step(1'b1, 1'b0, 32'h0);
      step(0, 1, 32'h1);
      chk("load1", {31'b0, q1}, 32'h1);

      // Reset raised 4 ns after an edge acts without a clock
      @(posedge clk);
      #4;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst_q1", {31'b0, q1}, 32'h0);
      chk("async_rst_q8", {24'b0, q8}, 32'hA5);
      repeat (3) step(1, 1, 32'hFFFF_FFFF);
      chk("rst_hold", {31'b0, q1}, 32'h0);

      step(0, 0, 32'h0);
      step(0, 0, 32'h1);
      step(0, 0, 32'h0);
      step(0, 0, 32'h1);
      chk("en_low_hold", {31'b0, q1}, 32'h0);

      for (int i = 0; i < 6; i++) begin
         step(0, 1, {31'b0, seq[i]});
         chk("en_high_seq", {31'b0, q1}, {31'b0, seq[i]});
      end

      step(0, 1, 32'h1);
      repeat (3) step(0, 0, 32'h0);
      chk("redisable_hold", {31'b0, q1}, 32'h1);
      step(0, 1, 32'h0);
      chk("reenable_load", {31'b0, q1}, 32'h0);

      // Reset and clock edge coincide
      step(0, 1, 32'h1);
      @(posedge clk);
      reset <= 1'b1;
      model_reset();
      #1;
      chk("rst_at_edge", {31'b0, q1}, 32'h0);
      step(1, 1, 32'h1);
      @(posedge clk);
      reset <= 1'b0;
      #1;
      chk("rel_at_edge_noload", {31'b0, q1}, 32'h0);
      chk("rel_at_edge_q8", {24'b0, q8}, 32'hA5);
      step(0, 1, 32'h1);
      chk("first_load_after_rel", {31'b0, q1}, 32'h1);

      step(1, 0, 32'h0);
      chk("w32_rst", q32, 32'h0000_0000);
      step(0, 1, 32'hDEAD_BEEF);
      chk("w32_load", q32, 32'hDEAD_BEEF);
      chk("w8_load", {24'b0, q8}, 32'hEF);
      step(0, 0, 32'h1234_5678);
      chk("w32_hold", q32, 32'hDEAD_BEEF);

      repeat (400) begin
         step(($urandom_range(15) == 0), $urandom_range(1) == 1,
              $urandom);
      end

      mvalid = 1'b0;
      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
